mini_cpu_core: RTL and testbench

Parametrised execution core for the mini CPU: accepts one encoded instruction per valid/ready handshake, executes it against an internal register file, and reports the affected register and value for the display path. It generalises the board-level mini CPU in three ways. Data width, register count and immediate width are parameters. It adds status flags and a retired-instruction counter. Switch/button sampling and LCD driving stay in the top level, which feeds `in_instr` and consumes the `out_*` report.

---
 rtl/mini_cpu_core.sv | 148 ++++++++++++++
 tb/tb_mini_cpu_core.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mini_cpu_core.sv
// mini_cpu_core: four-state core (IDLE/READ/EXEC/REPORT) with a register file, signed immediates, Z/N/V flags, a retired counter and a one-cycle report port
module mini_cpu_core #(
  parameter int DATA_W = 16,
  parameter int REG_COUNT = 16,
  parameter int IMM_W = 7,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(REG_COUNT),
  localparam int INSTR_W = 3 + 2*AW + IMM_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  output logic [2:0]         out_opcode,
  output logic [AW-1:0]      out_reg,
  output logic [DATA_W-1:0]  out_value,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_v,
  output logic [CNT_W-1:0]   retired
);
  localparam int M = DATA_W - 1;
  typedef enum logic [1:0] {IDLE, READ, EXEC, REPORT} state_t;
  state_t state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, val_q, val_d;
  logic [DATA_W-1:0] rf_q [REG_COUNT];
  logic [DATA_W-1:0] rf_d [REG_COUNT];
  logic z_q, z_d, n_q, n_d, v_q, v_d, ov_q, ov_d;
  logic [2:0] opc_q, opc_d;
  logic [AW-1:0] reg_q, reg_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [2:0] op;
  logic [AW-1:0] dst, src1, src2;
  logic [IMM_W-1:0] operand;
  logic [DATA_W-1:0] mag, rhs, res;
  logic [2*DATA_W-1:0] prod;
  logic is_add, is_sub, ovf;
  assign op      = instr_q[INSTR_W-1 -: 3];
  assign dst     = instr_q[2*AW+IMM_W-1 -: AW];
  assign src1    = instr_q[AW+IMM_W-1 -: AW];
  assign operand = instr_q[IMM_W-1:0];
  assign src2    = operand[AW-1:0];
  assign mag     = DATA_W'(operand[IMM_W-2:0]);
  assign is_add  = op == 3'd1 || op == 3'd2;
  assign is_sub  = op == 3'd3 || op == 3'd4;
  assign rhs     = (op == 3'd1 || op == 3'd3) ? b_q : imm_q;
  // Both operands sign-extended to 2*DATA_W, so the low 2*DATA_W bits are the exact signed product
  assign prod    = {{DATA_W{a_q[M]}}, a_q} * {{DATA_W{imm_q[M]}}, imm_q};
  assign res = op == 3'd0 ? imm_q :
               is_add     ? a_q + rhs :
               is_sub     ? a_q - rhs :
               op == 3'd5 ? prod[DATA_W-1:0] : '0;
  assign ovf = is_add     ? (a_q[M] == rhs[M] && res[M] != a_q[M]) :
               is_sub     ? (a_q[M] != rhs[M] && res[M] != a_q[M]) :
               op == 3'd5 ? !(&prod[2*DATA_W-1:M] || ~|prod[2*DATA_W-1:M]) : 1'b0;
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d = a_q;
    b_d = b_q;
    imm_d = imm_q;
    rf_d = rf_q;
    z_d = z_q;
    n_d = n_q;
    v_d = v_q;
    ov_d = 1'b0;
    opc_d = opc_q;
    reg_d = reg_q;
    val_d = val_q;
    ret_d = ret_q;
    case (state_q)
      IDLE: if (in_valid) begin
        instr_d = in_instr;
        state_d = READ;
      end
      READ: begin
        a_d = rf_q[src1];
        b_d = rf_q[src2];
        imm_d = operand[IMM_W-1] ? -mag : mag;
        state_d = EXEC;
      end
      EXEC: begin
        ov_d = 1'b1;
        opc_d = op;
        ret_d = ret_q + 1'b1;
        state_d = REPORT;
        if (op == 3'd7) begin
          reg_d = src1;
          val_d = a_q;
        end else begin
          z_d = res == '0;
          n_d = res[M];
          v_d = ovf;
          reg_d = op == 3'd6 ? '0 : dst;
          val_d = res;
          if (op == 3'd6) rf_d = '{default: '0};
          else rf_d[dst] = res;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      imm_q <= '0;
      rf_q <= '{default: '0};
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
      ov_q <= 1'b0;
      opc_q <= '0;
      reg_q <= '0;
      val_q <= '0;
      ret_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q <= a_d;
      b_q <= b_d;
      imm_q <= imm_d;
      rf_q <= rf_d;
      z_q <= z_d;
      n_q <= n_d;
      v_q <= v_d;
      ov_q <= ov_d;
      opc_q <= opc_d;
      reg_q <= reg_d;
      val_q <= val_d;
      ret_q <= ret_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = ov_q;
  assign out_opcode = opc_q;
  assign out_reg = reg_q;
  assign out_value = val_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_v = v_q;
  assign retired = ret_q;
endmodule

// File: tb/tb_mini_cpu_core.sv
// tb_mini_cpu_core: vector table, random stimulus against an arithmetic reference model, back-pressure and mid-instruction reset sequences
module tb_mini_cpu_core;
  logic clk = 0, reset_n = 0, in_valid = 0, in_ready, out_valid, flag_z, flag_n, flag_v;
  logic [17:0] in_instr = '0;
  logic [2:0] out_opcode;
  logic [3:0] out_reg;
  logic [15:0] out_value, retired;
  int errors = 0, checks = 0, ov_count = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid) ov_count++;
  mini_cpu_core dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_opcode(out_opcode), .out_reg(out_reg), .out_value(out_value),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .retired(retired)
  );
  typedef struct {
    logic [17:0] ins;
    logic [3:0] r;
    logic [15:0] val;
    logic fz, fn, fv;
  } vec_t;
  vec_t tbl [10];
  logic [15:0] mr [16];
  logic mz = 0, mn = 0, mv = 0;
  int mret = 0;
  logic [2:0] e_op;
  logic [3:0] e_reg;
  logic [15:0] e_val;
  logic [2:0] g_op;
  logic [3:0] g_reg;
  logic [15:0] g_val, g_ret;
  logic gz, gn, gv;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [15:0] ext(input logic [6:0] o);
    return o[6] ? 16'(-int'(o[5:0])) : 16'(o[5:0]);
  endfunction
  task automatic model(input logic [17:0] ins);
    logic [2:0] op;
    logic [3:0] d, s1, s2;
    logic [6:0] o;
    longint a, b, im, full;
    logic [15:0] res;
    op = ins[17:15]; d = ins[14:11]; s1 = ins[10:7]; o = ins[6:0]; s2 = o[3:0];
    a = longint'($signed(mr[s1]));
    b = longint'($signed(mr[s2]));
    im = longint'($signed(ext(o)));
    case (op)
      3'd0: full = im;
      3'd1: full = a + b;
      3'd2: full = a + im;
      3'd3: full = a - b;
      3'd4: full = a - im;
      3'd5: full = a * im;
      default: full = 0;
    endcase
    mret++;
    e_op = op;
    if (op == 3'd7) begin
      e_reg = s1;
      e_val = mr[s1];
    end else begin
      res = full[15:0];
      mz = res == 0;
      mn = res[15];
      mv = op >= 3'd1 && op <= 3'd5 && (full > 32767 || full < -32768);
      e_val = res;
      if (op == 3'd6) begin
        foreach (mr[i]) mr[i] = '0;
        e_reg = 0;
      end else begin
        mr[d] = res;
        e_reg = d;
      end
    end
  endtask
  task automatic run(input logic [17:0] ins);
    int n;
    @(negedge clk);
    in_valid = 1;
    in_instr = ins;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 in_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    chk("report_latency", n, 3);
    g_op = out_opcode; g_reg = out_reg; g_val = out_value;
    gz = flag_z; gn = flag_n; gv = flag_v; g_ret = retired;
    model(ins);
    @(negedge clk);
    chk("strobe_one_cycle", out_valid, 0);
  endtask
  task automatic cmp_model(input string nm);
    chk({nm, "_op"}, g_op, e_op);
    chk({nm, "_reg"}, g_reg, e_reg);
    chk({nm, "_val"}, g_val, e_val);
    chk({nm, "_flags"}, {gz, gn, gv}, {mz, mn, mv});
    chk({nm, "_retired"}, g_ret, 16'(mret));
  endtask
  initial begin
    int n, ovc0;
    logic [15:0] r0;
    foreach (mr[i]) mr[i] = '0;
    tbl[0] = '{18'b000_0011_0000_0000101, 4'd3, 16'h0005, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{18'b000_0100_0000_1000011, 4'd4, 16'hFFFD, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{18'b001_0101_0011_0000100, 4'd5, 16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{18'b000_0001_0000_0100000, 4'd1, 16'h0020, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{18'b101_0001_0001_0100000, 4'd1, 16'h0400, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{18'b101_0001_0001_0100000, 4'd1, 16'h8000, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{18'b100_0010_0001_0000001, 4'd2, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{18'b110_0101_0011_1111111, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{18'b111_1001_0101_0101010, 4'd5, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{18'b000_0111_0011_1000000, 4'd7, 16'h0000, 1'b1, 1'b0, 1'b0};
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outputs", {out_valid, out_opcode, out_reg, out_value, flag_z, flag_n, flag_v, retired}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      run(tbl[i].ins);
      chk($sformatf("vec%0d_op", i), g_op, tbl[i].ins[17:15]);
      chk($sformatf("vec%0d_reg", i), g_reg, tbl[i].r);
      chk($sformatf("vec%0d_val", i), g_val, tbl[i].val);
      chk($sformatf("vec%0d_flags", i), {gz, gn, gv}, {tbl[i].fz, tbl[i].fn, tbl[i].fv});
      chk($sformatf("vec%0d_retired", i), g_ret, 16'(i + 1));
    end
    ovc0 = ov_count;
    r0 = retired;
    @(negedge clk);
    in_valid = 1;
    in_instr = {3'd0, 4'd8, 4'd0, 7'd9};
    @(posedge clk);
    #1 in_instr = {3'd2, 4'd8, 4'd8, 7'd1};
    n = 0;
    while (!in_ready && n < 10) begin @(negedge clk); n++; end
    chk("busy_cycles", n, 4);
    @(posedge clk);
    #1 in_valid = 0;
    repeat (12) @(negedge clk);
    model({3'd0, 4'd8, 4'd0, 7'd9});
    model({3'd2, 4'd8, 4'd8, 7'd1});
    chk("held_reports", ov_count - ovc0, 2);
    chk("held_retired", 16'(retired - r0), 2);
    chk("held_value", out_value, e_val);
    chk("held_value_abs", out_value, 16'd10);
    for (int i = 0; i < 60; i++) begin
      run(18'($urandom));
      cmp_model("rand");
    end
    @(negedge clk);
    in_valid = 1;
    in_instr = {3'd2, 4'd6, 4'd6, 7'd7};
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #1 ovc0 = ov_count;
    reset_n = 0;
    #1;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_outputs", {out_valid, out_opcode, out_reg, out_value, flag_z, flag_n, flag_v, retired}, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (6) @(negedge clk);
    chk("midreset_no_report", ov_count - ovc0, 0);
    foreach (mr[i]) mr[i] = '0;
    mz = 0; mn = 0; mv = 0; mret = 0;
    run({3'd7, 4'd0, 4'd6, 7'd0});
    cmp_model("after_reset_display");
    chk("after_reset_r6", g_val, 0);
    chk("after_reset_retired", g_ret, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
